// File: rtl/timer_prescaler_if.sv
// timer_prescaler_if: TCR write strobe/fields in, count-enable and reconfigure pulses out
interface timer_prescaler_if #(parameter int CKS_W = 2);
  logic             tcr_wr;
  logic             tcr_en;
  logic [CKS_W-1:0] tcr_cks;
  logic             count_en;
  logic             tcr_reconf;
  logic             running;
  modport master (output tcr_wr, tcr_en, tcr_cks, input count_en, tcr_reconf, running);
  modport slave  (input tcr_wr, tcr_en, tcr_cks, output count_en, tcr_reconf, running);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides pclk by 2^(cks+1) into count_en pulses, with tcr_reconf on every enabling TCR write
module timer_prescaler #(
  parameter int DIV_W = 8,
  parameter int CKS_W = 2
) (
  input logic               pclk,
  input logic               preset,
  timer_prescaler_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RECONF, RUN} state_t;
  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n, term;
  logic [CKS_W-1:0] cks_q;
  logic             cnt_en_q, cnt_en_n;
  // RECONF is phase 0 of the division, so the first pulse lands exactly one divisor after tcr_reconf
  always_comb begin
    term = DIV_W'((32'd2 << cks_q) - 32'd1);
    state_n = state;
    div_n = '0;
    cnt_en_n = 1'b0;
    if (bus.tcr_wr) state_n = bus.tcr_en ? RECONF : IDLE;
    else if (state != IDLE) begin
      state_n = RUN;
      div_n = (div_cnt == term) ? '0 : div_cnt + 1'b1;
      cnt_en_n = div_cnt == term;
    end
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      div_cnt <= '0;
      cks_q <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= div_n;
      cnt_en_q <= cnt_en_n;
      if (bus.tcr_wr) cks_q <= bus.tcr_cks;
    end
  end
  assign bus.count_en = cnt_en_q;
  assign bus.tcr_reconf = state == RECONF;
  assign bus.running = state == RUN;
endmodule
